// File: rtl/mux_arb.sv
// N-channel valid/ready multiplexer with direct or round-robin selection and one registered output stage.
// Optional burst lock (in_last releases it) is built when MUX_ARB_LOCK_EN is defined.
module mux_arb #(
  parameter int WIDTH = 32,
  parameter int NCH   = 16,
  parameter int SELW  = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_g;
  logic            rr_ok;
  logic [SELW-1:0] g;
  logic            grant_ok;
  logic            load;
  logic            transfer;

  // The output register can take a new beat when it is empty or being drained.
  assign load     = !out_valid || out_ready;
  assign transfer = grant_ok && load;

  // Round-robin search: the loop runs from the farthest offset down so the
  // nearest valid channel after rr_ptr is the last (winning) assignment.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    rr_ok = 1'b0;
    rr_g  = '0;
    for (int k = NCH; k >= 1; k--) begin
      if (in_valid[(int'(rr_ptr) + k) % NCH]) begin
        rr_ok = 1'b1;
        rr_g  = SELW'((int'(rr_ptr) + k) % NCH);
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  logic            lock_q;
  logic [SELW-1:0] lock_ch;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
    end else if (transfer) begin
      lock_q  <= !in_last[g];
      lock_ch <= g;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  always_comb begin
    g        = '0;
    grant_ok = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    if (lock_q) begin
      g        = lock_ch;
      grant_ok = in_valid[lock_ch];
    end else
`endif
    if (!mode) begin
      // Out-of-range selects (NCH not a power of two) never grant.
      if (int'(sel) < NCH) begin
        g        = sel;
        grant_ok = in_valid[sel];
      end
    end else begin
      g        = rr_g;
      grant_ok = rr_ok;
    end
  end

  always_comb begin
    in_ready = '0;
    if (transfer) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(NCH - 1);
    end else begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
        out_ch    <= g;
        if (mode) rr_ptr <= g;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: directed scenarios then randomized traffic
// against a behavioural reference model (follows MUX_ARB_LOCK_EN if defined).
module tb_mux_arb;
  localparam int W = 32;
  localparam int N = 16;
  localparam int S = 4;
  localparam int N12 = 12;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           mode = 1'b0;
  logic [S-1:0]   sel = '0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [S-1:0]   out_ch;
  logic           out_ready;

  logic [N12*W-1:0] in_data12;
  logic [N12-1:0]   in_valid12;
  logic [N12-1:0]   in_last12;
  logic [N12-1:0]   in_ready12;
  logic [W-1:0]     out_data12;
  logic             out_valid12;
  logic [S-1:0]     out_ch12;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_ptr;
  bit           m_lock;
  int           m_lock_ch;

  mux_arb #(.WIDTH(W), .NCH(N), .SELW(S)) u_dut (
    .clk(clk), .resetn(resetn), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
  );

  mux_arb #(.WIDTH(W), .NCH(N12), .SELW(S)) u_dut12 (
    .clk(clk), .resetn(resetn), .mode(mode), .sel(sel),
    .in_data(in_data12), .in_valid(in_valid12), .in_last(in_last12), .in_ready(in_ready12),
    .out_data(out_data12), .out_valid(out_valid12), .out_ch(out_ch12), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_data    = '0;
    m_ch      = 0;
    m_ptr     = N - 1;
    m_lock    = 1'b0;
    m_lock_ch = 0;
  endtask

  task automatic exp_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (m_lock) begin
      g  = m_lock_ch;
      ok = in_valid[g];
    end else if (!mode) begin
      g  = int'(sel);
      ok = (g < N) && in_valid[g];
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!ok && in_valid[(m_ptr + k) % N]) begin
          ok = 1'b1;
          g  = (m_ptr + k) % N;
        end
      end
    end
  endtask

  // Compare against the model mid-cycle, then advance the model at the edge.
  task automatic step(input string tag);
    bit ok;
    int g;
    bit ld;
    logic [N-1:0] er;
    @(negedge clk);
    exp_grant(ok, g);
    ld = !m_valid || out_ready;
    er = '0;
    if (ok && ld) er[g] = 1'b1;
    check({tag, ".in_ready"}, in_ready, er);
    check({tag, ".out_valid"}, out_valid, m_valid);
    check({tag, ".out_data"}, out_data, m_data);
    check({tag, ".out_ch"}, out_ch, m_ch);
    @(posedge clk);
    if (ok && ld) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_ch    = g;
      if (mode) m_ptr = g;
`ifdef MUX_ARB_LOCK_EN
      m_lock    = !in_last[g];
      m_lock_ch = g;
`endif
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data", out_data, 0);
    check("rst.out_ch", out_ch, 0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    int ord3 [5];
    int ord6 [4];
    int c2;
    logic [W-1:0] held;

    in_valid   = '0;
    in_last    = '0;
    out_ready  = 1'b1;
    in_valid12 = '1;
    in_last12  = '0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA5A5_0000 | W'(i);
    for (int i = 0; i < N12; i++) in_data12[i*W +: W] = $urandom;
    model_reset();

    // Power-on reset
    #2;
    check("por.out_valid", out_valid, 0);
    check("por.out_data", out_data, 0);
    check("por.out_ch", out_ch, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // 1: reset mid-stream, then first round-robin grant is channel 0
    mode = 1'b1;
    in_valid = 16'h0010;
    step("t1.load");
    check("t1.held_valid", out_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t1.async_valid", out_valid, 0);
    check("t1.async_data", out_data, 0);
    check("t1.async_ch", out_ch, 0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    in_valid = 16'hFFFF;
    #1;
    check("t1.first_grant", in_ready, 16'h0001);
    step("t1.after");

    // 2: direct select of channel 5
    mode = 1'b0;
    sel = 4'd5;
    #1;
    check("t2.in_ready", in_ready, 16'h0020);
    for (int i = 0; i < 3; i++) step("t2");
    check("t2.out_data", out_data, 32'hA5A5_0005);
    check("t2.out_ch", out_ch, 5);
    check("t2.out_valid", out_valid, 1);

    // 3: round-robin order among channels 0, 8, 15
    do_reset();
    mode = 1'b1;
    in_valid = 16'h8101;
    ord3 = '{0, 8, 15, 0, 8};
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3.grant", in_ready, 64'(1) << ord3[i]);
      step("t3");
      check("t3.out_ch", out_ch, ord3[i]);
    end

    // 4: backpressure holds the output beat
    in_valid = 16'hFFFF;
    step("t4.fill");
    out_ready = 1'b0;
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step("t4.stall");
      check("t4.stable", out_data, held);
      check("t4.no_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("t4.reload", in_ready != 0, 1);
    step("t4.resume");

    // 5: out-of-range select on a 12-channel instance
    do_reset();
    mode = 1'b0;
    sel = 4'd13;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5.ready12", in_ready12, 0);
      check("t5.valid12", out_valid12, 0);
      step("t5");
    end
    sel = 4'd11;
    #1;
    check("t5.sel11_ready", in_ready12, 12'h800);
    step("t5.sel11");
    check("t5.sel11_ch", out_ch12, 11);
    check("t5.sel11_data", out_data12, in_data12[11*W +: W]);

    // 6: burst from channel 2 competing with channels 0 and 1
    do_reset();
    mode = 1'b1;
    in_valid = 16'h0002;
    in_last = 16'h0003;
    step("t6.ptr");
    in_valid = 16'h0007;
`ifdef MUX_ARB_LOCK_EN
    ord6 = '{2, 2, 2, 0};
`else
    ord6 = '{2, 0, 1, 2};
`endif
    c2 = 0;
    for (int i = 0; i < 4; i++) begin
      in_last[2] = (c2 == 2);
      #1;
      check("t6.grant", in_ready, 64'(1) << ord6[i]);
      step("t6");
      check("t6.out_ch", out_ch, ord6[i]);
      if (ord6[i] == 2) c2++;
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom);
      sel       = S'($urandom);
      in_valid  = (i % 3 == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      in_last   = N'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
      #1;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
